// File: rtl/chan_frame_packer_pkg.sv
// Shared constants for the channel frame packer: header default, channel count,
// FSM state encoding and the info-word builder.
package chan_frame_packer_pkg;

    localparam int          NUM_CH     = 3;
    localparam logic [15:0] HEADER_DEF = 16'hA55A;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_INFO = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_LAT  = 3'd4;
    localparam logic [2:0] ST_DATA = 3'd5;
    localparam logic [2:0] ST_CSUM = 3'd6;

    // Info word: channel number in the top nibble, burst length below it.
    function automatic logic [15:0] info_word(input logic [1:0] ch, input logic [11:0] burst);
        return {2'b00, ch, burst};
    endfunction

endpackage

// File: rtl/chan_frame_packer_checksum.sv
// Modular (carry-discarding) word accumulator used for the per-channel checksum.
module frame_checksum16 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_add_en,
    input  logic [W-1:0] i_addend,
    output logic [W-1:0] o_sum
);

    logic [W-1:0] r_sum;

    // Clear wins over add so a new frame never inherits a stale partial sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add_en) begin
            r_sum <= r_sum + i_addend;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/chan_frame_packer.sv
// Drains three channel FIFOs after each capture and emits one framed word stream
// (header, info, BURST_LEN samples, checksum) per channel over valid/ready.
module chan_frame_packer
    import chan_frame_packer_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                BURST_LEN = 256,
    parameter logic [DATA_W-1:0] HEADER    = DATA_W'(HEADER_DEF),
    parameter int                TIMEOUT   = 1024
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic              empty0,
    input  logic              empty1,
    input  logic              empty2,
    input  logic [DATA_W-1:0] q0,
    input  logic [DATA_W-1:0] q1,
    input  logic [DATA_W-1:0] q2,
    output logic              rdreq0,
    output logic              rdreq1,
    output logic              rdreq2,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err_pad,
    output logic [2:0]        dbg_state
);

    // Handshake: a word transfers on every rising Clk where out_valid && out_ready;
    // while out_valid is high and out_ready low, out_data/out_last hold unchanged.

    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);
    localparam logic [11:0]       BURST12  = 12'(BURST_LEN);
    localparam logic [11:0]       CNT_MAX  = 12'(BURST_LEN - 1);
    localparam logic [1:0]        LAST_CH  = 2'(NUM_CH - 1);

    logic [2:0]        r_state;
    logic [1:0]        r_ch;
    logic [11:0]       r_cnt;
    logic [WAIT_W-1:0] r_wait;
    logic [DATA_W-1:0] r_hold;
    logic              r_busy;
    logic              r_done;
    logic              r_err_pad;

    logic              w_empty;
    logic [DATA_W-1:0] w_q;
    logic              w_rd;
    logic              w_hs;
    logic              w_last_ch;
    logic [DATA_W-1:0] w_info;
    logic [DATA_W-1:0] w_sum;
    logic              w_sum_clr;
    logic              w_sum_add;

    always_comb begin
        w_empty = 1'b1;
        w_q     = '0;
        case (r_ch)
            2'd0: begin w_empty = empty0; w_q = q0; end
            2'd1: begin w_empty = empty1; w_q = q1; end
            2'd2: begin w_empty = empty2; w_q = q2; end
            default: begin w_empty = 1'b1; w_q = '0; end
        endcase
    end

    assign w_rd      = (r_state == ST_RD) && !w_empty;
    assign w_last_ch = (r_ch == LAST_CH);
    assign w_info    = DATA_W'(info_word(r_ch, BURST12));

    assign rdreq0 = w_rd && (r_ch == 2'd0);
    assign rdreq1 = w_rd && (r_ch == 2'd1);
    assign rdreq2 = w_rd && (r_ch == 2'd2);

    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        case (r_state)
            ST_HDR:  begin out_data = HEADER; out_valid = 1'b1; end
            ST_INFO: begin out_data = w_info; out_valid = 1'b1; end
            ST_DATA: begin out_data = r_hold; out_valid = 1'b1; end
            ST_CSUM: begin out_data = w_sum;  out_valid = 1'b1; end
            default: begin out_data = '0;     out_valid = 1'b0; end
        endcase
    end

    assign w_hs      = out_valid && out_ready;
    assign out_last  = (r_state == ST_CSUM) && w_last_ch;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_pad   = r_err_pad;
    assign dbg_state = r_state;

    // The checksum covers the info word and every sample; the header is excluded.
    assign w_sum_clr = ((r_state == ST_IDLE) && start) ||
                       ((r_state == ST_CSUM) && w_hs && !w_last_ch);
    assign w_sum_add = w_hs && ((r_state == ST_INFO) || (r_state == ST_DATA));

    frame_checksum16 #(
        .W (DATA_W)
    ) u_csum (
        .clk      (Clk),
        .rst      (Rst),
        .i_clr    (w_sum_clr),
        .i_add_en (w_sum_add),
        .i_addend (out_data),
        .o_sum    (w_sum)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= ST_IDLE;
            r_ch      <= '0;
            r_cnt     <= '0;
            r_wait    <= '0;
            r_hold    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err_pad <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_HDR;
                        r_busy    <= 1'b1;
                        r_err_pad <= 1'b0;
                        r_ch      <= '0;
                        r_cnt     <= '0;
                        r_wait    <= '0;
                    end
                end
                ST_HDR: begin
                    if (w_hs) r_state <= ST_INFO;
                end
                ST_INFO: begin
                    if (w_hs) r_state <= ST_RD;
                end
                ST_RD: begin
                    if (!w_empty) begin
                        r_wait  <= '0;
                        r_state <= ST_LAT;
                    end else if (r_wait == WAIT_MAX) begin
                        // Starved channel: substitute a zero sample and flag it.
                        r_wait    <= '0;
                        r_hold    <= '0;
                        r_err_pad <= 1'b1;
                        r_state   <= ST_DATA;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_LAT: begin
                    r_hold  <= w_q;
                    r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_hs) begin
                        if (r_cnt == CNT_MAX) begin
                            r_cnt   <= '0;
                            r_state <= ST_CSUM;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_hs) begin
                        if (w_last_ch) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_ch    <= r_ch + 1'b1;
                            r_state <= ST_HDR;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chan_frame_packer.sv
// Self-checking bench for chan_frame_packer: FIFO models, scenario table,
// word scoreboard, and a mid-frame reset sequence.
module tb_chan_frame_packer;
    import chan_frame_packer_pkg::*;

    localparam int TB_BURST   = 256;
    localparam int TB_TIMEOUT = 16;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        start;
    logic        empty0, empty1, empty2;
    logic [15:0] q0, q1, q2;
    logic        rdreq0, rdreq1, rdreq2;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy, done, err_pad;
    logic [2:0]  dbg_state;

    chan_frame_packer #(
        .DATA_W    (16),
        .BURST_LEN (TB_BURST),
        .HEADER    (16'hA55A),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .empty0    (empty0),
        .empty1    (empty1),
        .empty2    (empty2),
        .q0        (q0),
        .q1        (q1),
        .q2        (q2),
        .rdreq0    (rdreq0),
        .rdreq1    (rdreq1),
        .rdreq2    (rdreq2),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err_pad   (err_pad),
        .dbg_state (dbg_state)
    );

    // clock / counters
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;
    always @(posedge Clk) cycle++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // FIFO models: read data appears one cycle after rdreq
    logic [15:0] fifo_mem [3][4096];
    int          fifo_wr [3];
    int          fifo_rd [3];
    logic        flush_req = 1'b0;

    assign empty0 = (fifo_wr[0] == fifo_rd[0]);
    assign empty1 = (fifo_wr[1] == fifo_rd[1]);
    assign empty2 = (fifo_wr[2] == fifo_rd[2]);

    always @(posedge Clk) begin
        if (flush_req) begin
            for (int c = 0; c < 3; c++) fifo_rd[c] <= 0;
        end else begin
            if (rdreq0) begin
                chk("rdreq0_not_empty", {31'b0, empty0}, 32'd0);
                q0 <= fifo_mem[0][fifo_rd[0]];
                fifo_rd[0] <= fifo_rd[0] + 1;
            end
            if (rdreq1) begin
                chk("rdreq1_not_empty", {31'b0, empty1}, 32'd0);
                q1 <= fifo_mem[1][fifo_rd[1]];
                fifo_rd[1] <= fifo_rd[1] + 1;
            end
            if (rdreq2) begin
                chk("rdreq2_not_empty", {31'b0, empty2}, 32'd0);
                q2 <= fifo_mem[2][fifo_rd[2]];
                fifo_rd[2] <= fifo_rd[2] + 1;
            end
        end
    end

    task automatic flush_fifos();
        for (int c = 0; c < 3; c++) fifo_wr[c] = 0;
        flush_req = 1'b1;
        @(posedge Clk);
        #1 flush_req = 1'b0;
    endtask

    // ready driver
    bit rdy_rand = 1'b0;
    always @(posedge Clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // scoreboard: {last, data}
    logic [16:0] exp_q[$];
    bit          mon_en = 1'b0;
    int          run_words = 0;
    int          last_hs_cycle = -10;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data;

    always @(negedge Clk) begin
        if (mon_en) begin
            if (prev_stall)
                chk("stall_hold", {15'b0, out_valid, out_data}, {15'b0, 1'b1, prev_data});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", {15'b0, out_last, out_data}, 32'h1_FFFF);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    chk("word", {15'b0, out_last, out_data}, {15'b0, e});
                end
                run_words++;
                if (out_last) last_hs_cycle = cycle;
            end
        end
        prev_stall = mon_en && out_valid && !out_ready;
        prev_data  = out_data;
    end

    typedef struct {
        int fill;     // 0 ramp, 1 all-ones, 2 random
        int ch1_n;    // words preloaded into channel 1
        bit rdy;      // pseudo-random backpressure
        bit mid;      // extra start pulse mid ch0 frame
        bit exp_err;  // expected err_pad at done
    } scn_t;

    scn_t tbl[6];

    task automatic load_and_expect(input scn_t s, output int pads);
        logic [15:0] sum;
        logic [15:0] v;
        pads = 0;
        flush_fifos();
        for (int c = 0; c < 3; c++) begin
            int n;
            n = (c == 1) ? s.ch1_n : TB_BURST;
            for (int i = 0; i < n; i++) begin
                case (s.fill)
                    0:       v = 16'(i);
                    1:       v = 16'hFFFF;
                    default: v = 16'($urandom_range(0, 65535));
                endcase
                fifo_mem[c][i] = v;
            end
            fifo_wr[c] = n;
            exp_q.push_back({1'b0, 16'hA55A});
            sum = {4'(c), 12'(TB_BURST)};
            exp_q.push_back({1'b0, sum});
            for (int i = 0; i < TB_BURST; i++) begin
                v = (i < n) ? fifo_mem[c][i] : 16'h0000;
                if (i >= n) pads++;
                sum = sum + v;
                exp_q.push_back({1'b0, v});
            end
            exp_q.push_back({(c == 2), sum});
        end
    endtask

    task automatic run_scn(input scn_t s, input string tag);
        int  pads;
        int  t0;
        bit  got_done;
        load_and_expect(s, pads);
        rdy_rand  = s.rdy;
        run_words = 0;
        mon_en    = 1'b1;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        t0 = cycle;
        got_done = 1'b0;
        for (int k = 0; k < 30000; k++) begin
            @(negedge Clk);
            if (s.mid && k == 40) start = 1'b1;
            if (k == 41) start = 1'b0;
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, {31'b0, got_done}, 32'd1);
        if (got_done) begin
            chk({tag, "_words_left"}, exp_q.size(), 32'd0);
            chk({tag, "_done_after_last"}, cycle, last_hs_cycle + 1);
            chk({tag, "_err_pad"}, {31'b0, err_pad}, {31'b0, s.exp_err});
            chk({tag, "_busy_clear"}, {31'b0, busy}, 32'd0);
            if (pads > 0)
                chk({tag, "_pad_wait"}, {31'b0, ((cycle - t0) >= pads * TB_TIMEOUT)}, 32'd1);
            @(negedge Clk);
            chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        end
        exp_q.delete();
    endtask

    initial begin
        bit   hit;
        int   pads_unused;
        scn_t rs;
        tbl[0] = '{fill: 0, ch1_n: 256, rdy: 1'b0, mid: 1'b0, exp_err: 1'b0};
        tbl[1] = '{fill: 0, ch1_n: 256, rdy: 1'b1, mid: 1'b0, exp_err: 1'b0};
        tbl[2] = '{fill: 0, ch1_n: 10,  rdy: 1'b0, mid: 1'b0, exp_err: 1'b1};
        tbl[3] = '{fill: 0, ch1_n: 256, rdy: 1'b0, mid: 1'b1, exp_err: 1'b0};
        tbl[4] = '{fill: 1, ch1_n: 256, rdy: 1'b1, mid: 1'b0, exp_err: 1'b0};
        tbl[5] = '{fill: 2, ch1_n: 256, rdy: 1'b1, mid: 1'b0, exp_err: 1'b0};

        // reset block
        Rst   = 1'b1;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            fifo_wr[c] = 0;
        end
        #1;
        chk("reset_outputs",
            {20'b0, out_valid, out_data == 16'h0, out_last, busy, done, err_pad, rdreq0, rdreq1, rdreq2, dbg_state},
            {20'b0, 1'b0, 1'b1, 7'b0, ST_IDLE});
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        flush_fifos();

        for (int t = 0; t < 6; t++) run_scn(tbl[t], $sformatf("scn%0d", t));

        // reset in the middle of channel 1 data
        rs = '{fill: 0, ch1_n: 256, rdy: 1'b0, mid: 1'b0, exp_err: 1'b0};
        load_and_expect(rs, pads_unused);
        rdy_rand  = 1'b0;
        run_words = 0;
        mon_en    = 1'b1;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge Clk);
            if (run_words >= 280 && dbg_state == ST_DATA) begin
                hit = 1'b1;
                break;
            end
        end
        chk("rst_reach_ch1_data", {31'b0, hit}, 32'd1);
        mon_en = 1'b0;
        Rst    = 1'b1;
        #1;
        chk("rst_mid_outputs",
            {20'b0, out_valid, out_data == 16'h0, out_last, busy, done, err_pad, rdreq0, rdreq1, rdreq2, dbg_state},
            {20'b0, 1'b0, 1'b1, 7'b0, ST_IDLE});
        @(negedge Clk);
        Rst = 1'b0;
        exp_q.delete();
        run_scn(tbl[0], "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
